// File: rtl/spi_cmd_dispatch.sv
// spi_cmd_dispatch: sequences command/address/data words captured by
// spi_slave_top, decodes them and updates slot and LED configuration
// registers. Interrupt reads return the sticky pending bits during the
// address-to-data gap so the slave can shift them out.
module spi_cmd_dispatch #(
   parameter int NUM_SLOTS            = 7,
   parameter int NUM_INTRPTS          = 4,
   parameter int NUM_IO_PINS_PER_SLOT = 10,
   parameter int SLOT_TYPE_WIDTH      = 4,
   parameter int QUAD_CNTR_WIDTH      = 32,
   parameter int PWM_WIDTH            = 24
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [15:0]                               spi_cmd,
   input  logic                                      spi_cmd_valid,
   input  logic [7:0]                                spi_addr,
   input  logic                                      spi_addr_valid,
   input  logic [39:0]                               spi_data,
   input  logic                                      spi_data_valid,
   input  logic                                      spi_done,
   input  logic [NUM_SLOTS*NUM_INTRPTS-1:0]          intr_in,
   output logic [39:0]                               spi_sdo,
   output logic                                      spi_sdo_valid,
   output logic [PWM_WIDTH-1:0]                      pwm_period,
   output logic [PWM_WIDTH-1:0]                      pwm_duty,
   output logic [NUM_SLOTS*NUM_IO_PINS_PER_SLOT-1:0] dig_out,
   output logic [NUM_SLOTS*SLOT_TYPE_WIDTH-1:0]      slot_type,
   output logic [NUM_SLOTS-1:0]                      quad_set,
   output logic [QUAD_CNTR_WIDTH-1:0]                quad_set_value,
   output logic                                      cmd_err
);

   // Command codes shared with the host firmware
   localparam logic [15:0] C_SET_PWM_FREQ         = 16'h0010;
   localparam logic [15:0] C_SET_PWM_DUTY         = 16'h0011;
   localparam logic [15:0] C_SET_DIG_OUT          = 16'h0020;
   localparam logic [15:0] C_SET_SLOT_TYPE_CONFIG = 16'h0021;
   localparam logic [15:0] C_SET_QUAD_COUNTS      = 16'h0030;
   localparam logic [15:0] C_READ_INTERUPTS       = 16'h0040;

   // Address codes: slot cards are contiguous starting at SLOT_1_ADDRESS
   localparam logic [7:0] SLOT_1_ADDRESS = 8'h01;
   localparam logic [7:0] LED_ADDRESS    = 8'h10;

   localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int NUM_INTR_BITS = NUM_SLOTS * NUM_INTRPTS;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_RESP = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_EXEC = 3'd4;

   logic [2:0]               state;
   logic [15:0]              cmd_q;
   logic [SLOT_W-1:0]        slot_q;
   logic                     err_q;
   logic [39:0]              data_q;
   logic [NUM_INTR_BITS-1:0] intr_pend;

   logic addr_is_slot;
   logic addr_is_led;
   logic addr_ok;
   logic addr_read;

   logic [PWM_WIDTH-1:0] data_pwm;
   logic                 data_unused;

   assign data_pwm    = data_q[PWM_WIDTH-1:0];
   assign data_unused = ^data_q;

   // Decode the latched command against the incoming address word
   always_comb begin
      addr_is_slot = (spi_addr >= SLOT_1_ADDRESS) &&
                     (spi_addr <  SLOT_1_ADDRESS + 8'(NUM_SLOTS));
      addr_is_led  = (spi_addr == LED_ADDRESS);
      addr_ok      = 1'b0;
      addr_read    = 1'b0;
      case (cmd_q)
         C_SET_PWM_FREQ,
         C_SET_PWM_DUTY:         addr_ok = addr_is_led;
         C_SET_DIG_OUT,
         C_SET_SLOT_TYPE_CONFIG,
         C_SET_QUAD_COUNTS:      addr_ok = addr_is_slot;
         C_READ_INTERUPTS: begin
            addr_ok   = addr_is_slot;
            addr_read = 1'b1;
         end
         default:                addr_ok = 1'b0;
      endcase
   end

   // Transaction sequencer, register writes and interrupt capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         cmd_q          <= '0;
         slot_q         <= '0;
         err_q          <= 1'b0;
         data_q         <= '0;
         intr_pend      <= '0;
         spi_sdo        <= '0;
         spi_sdo_valid  <= 1'b0;
         pwm_period     <= '0;
         pwm_duty       <= '0;
         dig_out        <= '0;
         slot_type      <= '0;
         quad_set       <= '0;
         quad_set_value <= '0;
         cmd_err        <= 1'b0;
      end else begin
         spi_sdo_valid <= 1'b0;
         cmd_err       <= 1'b0;
         quad_set      <= '0;
         intr_pend     <= intr_pend | intr_in;

         // A new command always wins over chip-select release and over
         // the normal state action, so an abort never also produces a
         // response or a register write.
         if (spi_cmd_valid && (state != S_IDLE)) begin
            cmd_err <= 1'b1;
            cmd_q   <= spi_cmd;
            state   <= S_ADDR;
         end else if (spi_done && (state == S_ADDR || state == S_RESP ||
                                   state == S_DATA)) begin
            cmd_err <= 1'b1;
            state   <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (spi_cmd_valid) begin
                     cmd_q <= spi_cmd;
                     state <= S_ADDR;
                  end
               end
               S_ADDR: begin
                  if (spi_addr_valid) begin
                     slot_q <= SLOT_W'(spi_addr - SLOT_1_ADDRESS);
                     err_q  <= ~addr_ok;
                     state  <= (addr_ok && addr_read) ? S_RESP : S_DATA;
                  end
               end
               S_RESP: begin
                  spi_sdo       <= 40'(intr_pend);
                  spi_sdo_valid <= 1'b1;
                  // Reported bits clear; lines still high this cycle re-arm
                  intr_pend     <= intr_in;
                  state         <= S_DATA;
               end
               S_DATA: begin
                  if (spi_data_valid) begin
                     data_q <= spi_data;
                     state  <= S_EXEC;
                  end
               end
               S_EXEC: begin
                  state <= S_IDLE;
                  if (err_q) begin
                     cmd_err <= 1'b1;
                  end else begin
                     case (cmd_q)
                        C_SET_PWM_FREQ: begin
                           pwm_period <= data_pwm;
                           if (pwm_duty > data_pwm)
                              pwm_duty <= data_pwm;
                        end
                        C_SET_PWM_DUTY: begin
                           pwm_duty <= (data_pwm > pwm_period) ? pwm_period : data_pwm;
                        end
                        C_SET_DIG_OUT: begin
                           dig_out[int'(slot_q)*NUM_IO_PINS_PER_SLOT +: NUM_IO_PINS_PER_SLOT]
                              <= data_q[NUM_IO_PINS_PER_SLOT-1:0];
                        end
                        C_SET_SLOT_TYPE_CONFIG: begin
                           slot_type[int'(slot_q)*SLOT_TYPE_WIDTH +: SLOT_TYPE_WIDTH]
                              <= data_q[SLOT_TYPE_WIDTH-1:0];
                        end
                        C_SET_QUAD_COUNTS: begin
                           quad_set_value   <= data_q[QUAD_CNTR_WIDTH-1:0];
                           quad_set[slot_q] <= 1'b1;
                        end
                        default: begin
                        end
                     endcase
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_cmd_dispatch.sv
// Bench for spi_cmd_dispatch: directed cases with literal expectations and
// randomized transactions, all checked every cycle against a transaction
// level model of the register file, response and error pulses.
module tb_spi_cmd_dispatch;

   localparam int NS = 7, NI = 4, NIO = 10, STW = 4, QW = 32, PW = 24;

   localparam logic [15:0] C_FREQ = 16'h0010;
   localparam logic [15:0] C_DUTY = 16'h0011;
   localparam logic [15:0] C_DIG  = 16'h0020;
   localparam logic [15:0] C_TYPE = 16'h0021;
   localparam logic [15:0] C_QUAD = 16'h0030;
   localparam logic [15:0] C_READ = 16'h0040;
   localparam logic [7:0]  LED    = 8'h10;

   localparam int M_NORMAL = 0, M_DONE = 1, M_RESTART = 2, M_RESET = 3;

   logic                clk = 1'b0;
   logic                reset;
   logic [15:0]         spi_cmd;
   logic                spi_cmd_valid;
   logic [7:0]          spi_addr;
   logic                spi_addr_valid;
   logic [39:0]         spi_data;
   logic                spi_data_valid;
   logic                spi_done;
   logic [NS*NI-1:0]    intr_in;
   logic [39:0]         spi_sdo;
   logic                spi_sdo_valid;
   logic [PW-1:0]       pwm_period, pwm_duty;
   logic [NS*NIO-1:0]   dig_out;
   logic [NS*STW-1:0]   slot_type;
   logic [NS-1:0]       quad_set;
   logic [QW-1:0]       quad_set_value;
   logic                cmd_err;

   spi_cmd_dispatch #(
      .NUM_SLOTS(NS), .NUM_INTRPTS(NI), .NUM_IO_PINS_PER_SLOT(NIO),
      .SLOT_TYPE_WIDTH(STW), .QUAD_CNTR_WIDTH(QW), .PWM_WIDTH(PW)
   ) dut (
      .clk(clk), .reset(reset),
      .spi_cmd(spi_cmd), .spi_cmd_valid(spi_cmd_valid),
      .spi_addr(spi_addr), .spi_addr_valid(spi_addr_valid),
      .spi_data(spi_data), .spi_data_valid(spi_data_valid),
      .spi_done(spi_done), .intr_in(intr_in),
      .spi_sdo(spi_sdo), .spi_sdo_valid(spi_sdo_valid),
      .pwm_period(pwm_period), .pwm_duty(pwm_duty),
      .dig_out(dig_out), .slot_type(slot_type),
      .quad_set(quad_set), .quad_set_value(quad_set_value),
      .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   int n_assert = 0, n_fail = 0, cyc = 0;
   int last_addr_cyc = 0, sdo_seen_cyc = -100, err_seen = 0;
   logic [39:0] sdo_seen_val = '0;

   // Model state
   logic [PW-1:0]  m_period, m_duty;
   logic [NIO-1:0] m_dig [NS];
   logic [STW-1:0] m_type [NS];
   logic [QW-1:0]  m_qval;
   logic [39:0]    m_sdo;
   logic [NS*NI-1:0] m_pend;
   bit exp_err = 0, exp_sdo_v = 0;
   logic [NS-1:0] exp_quad = '0;
   bit chk_en = 0, in_resp = 0, intr_rand = 0, force_en = 0;
   logic [NS*NI-1:0] force_val = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      m_period = '0; m_duty = '0; m_qval = '0; m_sdo = '0; m_pend = '0;
      for (int s = 0; s < NS; s++) begin
         m_dig[s] = '0;
         m_type[s] = '0;
      end
   endtask

   // 0 = rejected, 1 = interrupt read, 2 = write
   function automatic int kind_of(input logic [15:0] c, input logic [7:0] a);
      bit slot = (a >= 8'd1) && (a <= 8'd7);
      bit led  = (a == LED);
      case (c)
         C_FREQ, C_DUTY:         return led ? 2 : 0;
         C_DIG, C_TYPE, C_QUAD:  return slot ? 2 : 0;
         C_READ:                 return slot ? 1 : 0;
         default:                return 0;
      endcase
   endfunction

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         logic [NS*NIO-1:0] e_dig;
         logic [NS*STW-1:0] e_type;
         for (int s = 0; s < NS; s++) begin
            e_dig[s*NIO +: NIO]  = m_dig[s];
            e_type[s*STW +: STW] = m_type[s];
         end
         chk("pwm_period", pwm_period, m_period);
         chk("pwm_duty", pwm_duty, m_duty);
         chk("dig_out", dig_out, e_dig);
         chk("slot_type", slot_type, e_type);
         chk("quad_set", quad_set, exp_quad);
         chk("quad_set_value", quad_set_value, m_qval);
         chk("cmd_err", cmd_err, exp_err);
         chk("spi_sdo_valid", spi_sdo_valid, exp_sdo_v);
         chk("spi_sdo", spi_sdo, m_sdo);
         if (spi_sdo_valid === 1'b1) begin
            sdo_seen_cyc = cyc;
            sdo_seen_val = spi_sdo;
         end
         if (cmd_err === 1'b1) err_seen++;
      end
   end

   // Advance one cycle; retire the previous cycle's interrupt/reset effects
   task automatic next_cycle();
      logic [NS*NI-1:0] pi = intr_in;
      bit pr   = in_resp;
      bit prst = reset;
      @(posedge clk);
      #1;
      cyc++;
      if (prst)    model_clear();
      else if (pr) m_pend = pi;
      else         m_pend = m_pend | pi;
      in_resp = 0; reset = 0;
      spi_cmd_valid = 0; spi_addr_valid = 0; spi_data_valid = 0; spi_done = 0;
      exp_err = 0; exp_sdo_v = 0; exp_quad = '0;
      intr_in = (intr_rand && ($urandom_range(0, 7) == 0)) ?
                ((NS*NI)'(1) << $urandom_range(0, NS*NI-1)) : '0;
      if (force_en) intr_in = force_val;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) next_cycle();
   endtask

   // One transaction starting with the command pulse in the current cycle
   task automatic run_txn(input logic [15:0] cmd, input logic [7:0] addr,
                          input logic [39:0] data, input int mode_in,
                          input logic [15:0] cmd2);
      logic [15:0] c = cmd;
      int mode = mode_in;
      bit again = 1, err_next = 0;
      int k = 0;
      logic [39:0] snap;
      spi_cmd = c; spi_cmd_valid = 1;
      while (again) begin
         again = 0;
         next_cycle();
         if (err_next) exp_err = 1;
         err_next = 0;
         gap();
         spi_addr = addr; spi_addr_valid = 1; last_addr_cyc = cyc;
         k = kind_of(c, addr);
         next_cycle();
         if (k == 1) begin
            in_resp = 1;
            snap = 40'(m_pend);
            next_cycle();
            exp_sdo_v = 1;
            m_sdo = snap;
         end
         gap();
         if (mode == M_RESTART) begin
            spi_cmd = cmd2; spi_cmd_valid = 1;
            c = cmd2; mode = M_NORMAL; again = 1; err_next = 1;
         end
      end
      case (mode)
         M_DONE: begin
            spi_done = 1;
            next_cycle();
            exp_err = 1;
         end
         M_RESET: begin
            reset = 1;
            next_cycle();
         end
         default: begin
            spi_data = data; spi_data_valid = 1;
            next_cycle();
            next_cycle();
            if (k == 0) exp_err = 1;
            else if (k == 2) begin
               int s = int'(addr) - 1;
               logic [PW-1:0] d = data[PW-1:0];
               case (c)
                  C_FREQ: begin
                     m_period = d;
                     if (m_duty > m_period) m_duty = m_period;
                  end
                  C_DUTY: m_duty = (d < m_period) ? d : m_period;
                  C_DIG:  m_dig[s] = data[NIO-1:0];
                  C_TYPE: m_type[s] = data[STW-1:0];
                  C_QUAD: begin
                     m_qval = data[QW-1:0];
                     exp_quad = NS'(1) << s;
                  end
                  default: ;
               endcase
            end
         end
      endcase
   endtask

   task automatic do_reset();
      reset = 1;
      next_cycle();
      next_cycle();
   endtask

   task automatic read_intr(output logic [39:0] val, output int lat);
      sdo_seen_cyc = -100;
      run_txn(C_READ, 8'h07, 40'h0, M_NORMAL, 16'h0);
      val = sdo_seen_val;
      lat = sdo_seen_cyc - last_addr_cyc;
   endtask

   logic [15:0] cmd_list [8] = '{C_FREQ, C_DUTY, C_DIG, C_TYPE, C_QUAD, C_READ, 16'hffff, 16'h0000};

   initial begin
      logic [39:0] v;
      int lat, e0;
      reset = 1; spi_cmd = '0; spi_cmd_valid = 0; spi_addr = '0; spi_addr_valid = 0;
      spi_data = '0; spi_data_valid = 0; spi_done = 0; intr_in = '0;
      model_clear();
      repeat (3) begin next_cycle(); reset = 1; end
      next_cycle();
      chk_en = 1;
      chk("rst_pwm_period", pwm_period, 24'h0);
      chk("rst_dig_out", dig_out, 70'h0);
      chk("rst_spi_sdo", spi_sdo, 40'h0);

      // PWM period then duty
      run_txn(C_FREQ, LED, 40'h01234503e8, M_NORMAL, 16'h0);
      chk("freq_lit", pwm_period, 24'h4503e8);
      run_txn(C_DUTY, LED, 40'h00000001f4, M_NORMAL, 16'h0);
      chk("duty_lit", pwm_duty, 24'd500);

      // Clamping in both directions
      run_txn(C_FREQ, LED, 40'd1000, M_NORMAL, 16'h0);
      run_txn(C_DUTY, LED, 40'h00000007d0, M_NORMAL, 16'h0);
      chk("duty_clamp", pwm_duty, 24'd1000);
      run_txn(C_FREQ, LED, 40'd300, M_NORMAL, 16'h0);
      chk("freq_clamp_p", pwm_period, 24'd300);
      chk("freq_clamp_d", pwm_duty, 24'd300);

      // Slot 1 digital outputs and type
      do_reset();
      run_txn(C_DIG, 8'h01, 40'h1, M_NORMAL, 16'h0);
      run_txn(C_TYPE, 8'h01, 40'h1, M_NORMAL, 16'h0);
      chk("dig_lit", dig_out, 70'h1);
      chk("type_lit", slot_type, 28'h1);

      // Interrupt capture, clear and re-arm
      next_cycle();
      intr_in = 28'h10;
      next_cycle();
      read_intr(v, lat);
      chk("intr_read1", v, 40'h10);
      chk("intr_latency", lat, 2);
      read_intr(v, lat);
      chk("intr_read2", v, 40'h0);
      force_en = 1; force_val = 28'h10;
      read_intr(v, lat);
      force_en = 0; force_val = '0;
      chk("intr_read3", v, 40'h10);
      next_cycle();
      read_intr(v, lat);
      chk("intr_read4", v, 40'h10);
      read_intr(v, lat);
      chk("intr_read5", v, 40'h0);

      // Quadrature preset strobe
      run_txn(C_QUAD, 8'h01, 40'h00deadbeef, M_NORMAL, 16'h0);
      chk("quad_strobe", quad_set, 7'b0000001);
      chk("quad_value", quad_set_value, 32'hdeadbeef);
      next_cycle();
      chk("quad_strobe_off", quad_set, 7'b0);

      // Rejected transactions
      e0 = err_seen;
      run_txn(C_DIG, 8'h01, 40'h3ff, M_DONE, 16'h0);
      next_cycle();
      chk("err_done", err_seen - e0, 1);
      e0 = err_seen;
      run_txn(C_FREQ, 8'h03, 40'h5, M_NORMAL, 16'h0);
      next_cycle();
      chk("err_pwm_slot", err_seen - e0, 1);
      e0 = err_seen;
      run_txn(16'hffff, 8'h01, 40'h5, M_NORMAL, 16'h0);
      next_cycle();
      chk("err_unknown", err_seen - e0, 1);
      e0 = err_seen;
      run_txn(C_DIG, 8'h02, 40'h3ff, M_RESTART, C_TYPE);
      next_cycle();
      chk("err_restart", err_seen - e0, 1);
      chk("restart_type", slot_type, 28'hf1);
      run_txn(C_DIG, 8'h02, 40'h3ff, M_RESET, 16'h0);
      chk("reset_mid_dig", dig_out, 70'h0);
      chk("reset_mid_type", slot_type, 28'h0);
      run_txn(C_FREQ, LED, 40'd100, M_NORMAL, 16'h0);
      chk("after_reset_freq", pwm_period, 24'd100);

      // Randomized traffic
      intr_rand = 1;
      for (int t = 0; t < 300; t++) begin
         logic [15:0] c;
         logic [7:0] a;
         logic [39:0] d;
         int r, mode;
         c = cmd_list[$urandom_range(0, 7)];
         r = $urandom_range(0, 9);
         if (r <= 6)      a = 8'($urandom_range(1, 7));
         else if (r <= 8) a = LED;
         else             a = 8'($urandom_range(0, 255));
         d = {8'($urandom), 32'($urandom)};
         r = $urandom_range(0, 99);
         mode = (r < 80) ? M_NORMAL : (r < 87) ? M_DONE : (r < 94) ? M_RESTART : M_RESET;
         run_txn(c, a, d, mode, cmd_list[$urandom_range(0, 5)]);
         repeat ($urandom_range(0, 1)) next_cycle();
      end
      next_cycle();
      next_cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
